// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI command framer: FSM state encoding,
// default operand limit and the known command opcodes.
package spi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_WAIT_OPCODE = 2'd1,
      ST_OPERANDS    = 2'd2
   } spi_state_e;

   localparam int SPI_MAX_OPERANDS_DEF = 1024;

   localparam logic [7:0] OPC_ASSIGN_COLOR = 8'h10;
   localparam logic [7:0] OPC_BUFFER_SHOW  = 8'h17;
   localparam logic [7:0] OPC_DRAW_PIXEL   = 8'h19;

endpackage

// File: rtl/spi_command_framer.sv
// Splits a chip-select framed SPI byte stream into one opcode followed by
// numbered operand bytes; all outputs are registered (latency 1).
module spi_command_framer
   import spi_pkg::*;
#(
   parameter int MAX_OPERANDS = SPI_MAX_OPERANDS_DEF
) (
   input  logic        clock_in,
   input  logic        reset_n_in,
   input  logic        cs_active_in,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid_in,
   output logic [7:0]  op_code_out,
   output logic        op_code_valid_out,
   output logic [7:0]  operand_out,
   output logic        operand_valid_out,
   output logic [31:0] operand_count_out,
   output logic        transaction_done_out,
   output logic        overflow_out
);

   localparam logic [31:0] LP_MAX = 32'(MAX_OPERANDS);

   spi_state_e  r_state;
   spi_state_e  w_state_nxt;

   logic        w_accept;
   logic        w_cap_opcode;
   logic        w_take_operand;
   logic        w_drop_operand;
   logic        w_close;

   logic [7:0]  r_op_code;
   logic        r_op_code_valid;
   logic [7:0]  r_operand;
   logic        r_operand_valid;
   logic [31:0] r_count;
   logic        r_done;
   logic        r_overflow;

   // A byte only counts when chip select is still high in the same cycle.
   assign w_accept = byte_valid_in & cs_active_in;

   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) r_state <= ST_IDLE;
      else             r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cap_opcode   = 1'b0;
      w_take_operand = 1'b0;
      w_drop_operand = 1'b0;
      w_close        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (cs_active_in) w_state_nxt = ST_WAIT_OPCODE;
         end
         ST_WAIT_OPCODE: begin
            if (!cs_active_in) begin
               w_state_nxt = ST_IDLE;
               w_close     = 1'b1;
            end else if (w_accept) begin
               w_state_nxt  = ST_OPERANDS;
               w_cap_opcode = 1'b1;
            end
         end
         ST_OPERANDS: begin
            if (!cs_active_in) begin
               w_state_nxt = ST_IDLE;
               w_close     = 1'b1;
            end else if (w_accept) begin
               if (r_count < LP_MAX) w_take_operand = 1'b1;
               else                  w_drop_operand = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Close has priority: it clears the per-transaction flags and count,
   // while opcode and operand data keep their last values.
   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         r_op_code       <= '0;
         r_op_code_valid <= 1'b0;
         r_operand       <= '0;
         r_operand_valid <= 1'b0;
         r_count         <= '0;
         r_done          <= 1'b0;
         r_overflow      <= 1'b0;
      end else begin
         r_operand_valid <= w_take_operand;
         r_done          <= w_close & r_op_code_valid;
         if (w_cap_opcode) begin
            r_op_code       <= byte_in;
            r_op_code_valid <= 1'b1;
            r_count         <= '0;
         end
         if (w_take_operand) begin
            r_operand <= byte_in;
            r_count   <= r_count + 32'd1;
         end
         if (w_drop_operand) r_overflow <= 1'b1;
         if (w_close) begin
            r_op_code_valid <= 1'b0;
            r_count         <= '0;
            r_overflow      <= 1'b0;
         end
      end
   end

   assign op_code_out          = r_op_code;
   assign op_code_valid_out    = r_op_code_valid;
   assign operand_out          = r_operand;
   assign operand_valid_out    = r_operand_valid;
   assign operand_count_out    = r_count;
   assign transaction_done_out = r_done;
   assign overflow_out         = r_overflow;

endmodule

// File: tb/tb_spi_command_framer.sv
// Randomised and directed checks of spi_command_framer against a transaction
// level model; two instances share stimulus, one with a small operand limit.
module tb_spi_command_framer;
   import spi_pkg::*;

   localparam int SMALL_MAX = 2;

   logic        clock_in = 1'b0;
   logic        reset_n_in = 1'b0;
   logic        cs_active_in = 1'b0;
   logic [7:0]  byte_in = 8'h00;
   logic        byte_valid_in = 1'b0;

   logic [7:0]  op_code[2];
   logic        op_code_v[2];
   logic [7:0]  operand[2];
   logic        operand_v[2];
   logic [31:0] count[2];
   logic        done[2];
   logic        ovf[2];

   int total = 0;
   int bad   = 0;

   always #5 clock_in = ~clock_in;

   spi_command_framer u_big (
      .clock_in(clock_in), .reset_n_in(reset_n_in), .cs_active_in(cs_active_in),
      .byte_in(byte_in), .byte_valid_in(byte_valid_in),
      .op_code_out(op_code[0]), .op_code_valid_out(op_code_v[0]),
      .operand_out(operand[0]), .operand_valid_out(operand_v[0]),
      .operand_count_out(count[0]), .transaction_done_out(done[0]),
      .overflow_out(ovf[0]));

   spi_command_framer #(.MAX_OPERANDS(SMALL_MAX)) u_small (
      .clock_in(clock_in), .reset_n_in(reset_n_in), .cs_active_in(cs_active_in),
      .byte_in(byte_in), .byte_valid_in(byte_valid_in),
      .op_code_out(op_code[1]), .op_code_valid_out(op_code_v[1]),
      .operand_out(operand[1]), .operand_valid_out(operand_v[1]),
      .operand_count_out(count[1]), .transaction_done_out(done[1]),
      .overflow_out(ovf[1]));

   // Transaction-level model: a transaction opens one cycle after cs is
   // seen high, its first accepted byte is the opcode, the rest are operands.
   int       lim[2] = '{SPI_MAX_OPERANDS_DEF, SMALL_MAX};
   bit       m_open[2], m_haveop[2], m_ovf[2], m_strobe[2], m_done[2];
   int       m_cnt[2];
   bit [7:0] m_op[2], m_opd[2];

   always @(posedge clock_in or negedge reset_n_in) begin
      for (int k = 0; k < 2; k++) begin
         m_strobe[k] = 1'b0;
         m_done[k]   = 1'b0;
         if (!reset_n_in) begin
            m_open[k] = 0; m_haveop[k] = 0; m_ovf[k] = 0;
            m_cnt[k] = 0; m_op[k] = 0; m_opd[k] = 0;
         end else if (!m_open[k]) begin
            if (cs_active_in) m_open[k] = 1;
         end else if (!cs_active_in) begin
            m_done[k] = m_haveop[k];
            m_open[k] = 0; m_haveop[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
         end else if (byte_valid_in) begin
            if (!m_haveop[k]) begin
               m_haveop[k] = 1; m_op[k] = byte_in; m_cnt[k] = 0;
            end else if (m_cnt[k] < lim[k]) begin
               m_cnt[k]++; m_opd[k] = byte_in; m_strobe[k] = 1;
            end else begin
               m_ovf[k] = 1;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clock_in) begin
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("op_code[%0d]", k),   32'(op_code[k]),   32'(m_op[k]));
         chk($sformatf("op_code_v[%0d]", k), 32'(op_code_v[k]), 32'(m_haveop[k]));
         chk($sformatf("operand[%0d]", k),   32'(operand[k]),   32'(m_opd[k]));
         chk($sformatf("operand_v[%0d]", k), 32'(operand_v[k]), 32'(m_strobe[k]));
         chk($sformatf("count[%0d]", k),     count[k],          32'(m_cnt[k]));
         chk($sformatf("done[%0d]", k),      32'(done[k]),      32'(m_done[k]));
         chk($sformatf("ovf[%0d]", k),       32'(ovf[k]),       32'(m_ovf[k]));
      end
   end

   // Drive one cycle of input; returns just after the edge that consumed it.
   task automatic step(input bit cs, input bit bv, input logic [7:0] b);
      cs_active_in  = cs;
      byte_valid_in = bv;
      byte_in       = b;
      @(posedge clock_in);
      #2;
   endtask

   task automatic all_zero(input string name, input int k);
      chk({name, " op"},   32'(op_code[k]),   32'h0);
      chk({name, " opv"},  32'(op_code_v[k]), 32'h0);
      chk({name, " opd"},  32'(operand[k]),   32'h0);
      chk({name, " opdv"}, 32'(operand_v[k]), 32'h0);
      chk({name, " cnt"},  count[k],          32'h0);
      chk({name, " done"}, 32'(done[k]),      32'h0);
      chk({name, " ovf"},  32'(ovf[k]),       32'h0);
   endtask

   initial begin
      #1;
      all_zero("reset", 0);
      all_zero("reset", 1);
      @(posedge clock_in); #2;
      reset_n_in = 1'b1;
      step(0, 0, 8'h00);

      // Opcode with four operands.
      step(1, 0, 8'h00);
      step(1, 1, OPC_ASSIGN_COLOR);
      chk("t1 opcode", 32'(op_code[0]), 32'h10);
      chk("t1 opv",    32'(op_code_v[0]), 32'h1);
      chk("t1 cnt0",   count[0], 32'd0);
      step(1, 1, 8'hA5);
      chk("t1 opd1", 32'(operand[0]), 32'hA5);
      chk("t1 cnt1", count[0], 32'd1);
      chk("t1 v1",   32'(operand_v[0]), 32'h1);
      step(1, 1, 8'h3C);
      step(1, 0, 8'h00);
      chk("t1 strobe once", 32'(operand_v[0]), 32'h0);
      step(1, 1, 8'h80);
      step(1, 1, 8'hE0);
      chk("t1 opd4", 32'(operand[0]), 32'hE0);
      chk("t1 cnt4", count[0], 32'd4);
      step(0, 0, 8'h00);
      chk("t1 done",  32'(done[0]), 32'h1);
      chk("t1 keep",  32'(op_code[0]), 32'h10);
      chk("t1 cnt cleared", count[0], 32'd0);
      step(0, 0, 8'h00);
      chk("t1 done once", 32'(done[0]), 32'h0);

      // Opcode only.
      step(1, 0, 8'h00);
      step(1, 1, OPC_BUFFER_SHOW);
      step(1, 0, 8'h00);
      chk("t2 opv", 32'(op_code_v[0]), 32'h1);
      step(0, 0, 8'h00);
      chk("t2 done", 32'(done[0]), 32'h1);

      // Overflow on the small instance.
      step(1, 0, 8'h00);
      step(1, 1, OPC_DRAW_PIXEL);
      step(1, 1, 8'h01);
      step(1, 1, 8'h02);
      chk("t3 cnt2", count[1], 32'd2);
      step(1, 1, 8'h03);
      chk("t3 dropped", 32'(operand_v[1]), 32'h0);
      chk("t3 cnt held", count[1], 32'd2);
      chk("t3 opd held", 32'(operand[1]), 32'h02);
      chk("t3 ovf", 32'(ovf[1]), 32'h1);
      step(1, 0, 8'h00);
      chk("t3 ovf held", 32'(ovf[1]), 32'h1);
      step(0, 0, 8'h00);
      chk("t3 ovf clr", 32'(ovf[1]), 32'h0);
      chk("t3 done", 32'(done[1]), 32'h1);

      // Byte coinciding with cs falling.
      step(1, 0, 8'h00);
      step(1, 1, OPC_ASSIGN_COLOR);
      step(1, 1, 8'h55);
      step(0, 1, 8'h77);
      chk("t4 no strobe", 32'(operand_v[0]), 32'h0);
      chk("t4 opd kept", 32'(operand[0]), 32'h55);
      chk("t4 done", 32'(done[0]), 32'h1);

      // Idle bytes and an empty cs pulse.
      step(0, 1, 8'hAA);
      step(0, 1, 8'hAB);
      step(1, 0, 8'h00);
      step(0, 0, 8'h00);
      chk("t5 no done", 32'(done[0]), 32'h0);
      chk("t5 opd kept", 32'(operand[0]), 32'h55);

      // One-cycle cs gap starts a fresh transaction.
      step(1, 0, 8'h00);
      step(1, 1, OPC_DRAW_PIXEL);
      step(1, 1, 8'h11);
      step(0, 0, 8'h00);
      step(1, 0, 8'h00);
      step(1, 1, 8'h42);
      chk("t6 new opcode", 32'(op_code[0]), 32'h42);
      chk("t6 cnt", count[0], 32'd0);
      step(0, 0, 8'h00);

      // Reset mid-transaction.
      step(1, 0, 8'h00);
      step(1, 1, OPC_ASSIGN_COLOR);
      step(1, 1, 8'h21);
      step(1, 1, 8'h22);
      cs_active_in = 1'b1; byte_valid_in = 1'b0;
      reset_n_in = 1'b0;
      #1;
      all_zero("midreset", 0);
      @(posedge clock_in); #2;
      chk("midreset no done", 32'(done[0]), 32'h0);
      reset_n_in = 1'b1;
      step(0, 0, 8'h00);
      step(1, 0, 8'h00);
      step(1, 1, OPC_DRAW_PIXEL);
      step(1, 1, 8'h07);
      chk("t7 cnt", count[0], 32'd1);
      chk("t7 opd", 32'(operand[0]), 32'h07);
      step(0, 0, 8'h00);

      // Random traffic.
      for (int i = 0; i < 4000; i++) begin
         step($urandom_range(0, 15) != 0, $urandom_range(0, 2) != 0,
              8'($urandom_range(0, 255)));
      end
      step(0, 0, 8'h00);
      step(0, 0, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_command_framer.md
SPI_COMMAND_FRAMER -- requirements
Module: spi_command_framer

Interface
REQ-001 Parameter MAX_OPERANDS, default 1024, maximum operand bytes accepted per transaction.
REQ-002 clock_in  input  1  system clock; all logic on its rising edge.
REQ-003 reset_n_in  input  1  asynchronous, active-low reset.
REQ-004 cs_active_in  input  1  SPI chip select, already synchronised to clock_in; 1 = transaction open.
REQ-005 byte_in  input  8  received SPI byte; valid only when byte_valid_in = 1.
REQ-006 byte_valid_in  input  1  one-cycle strobe per received byte.
REQ-007 op_code_out  output  8  opcode of the current transaction.
REQ-008 op_code_valid_out  output  1  high from opcode capture until transaction end.
REQ-009 operand_out  output  8  most recent operand byte.
REQ-010 operand_valid_out  output  1  one-cycle strobe per accepted operand.
REQ-011 operand_count_out  output  32 (integer)  1-based index of operand_out within the transaction.
REQ-012 transaction_done_out  output  1  one-cycle strobe when a transaction that carried an opcode closes.
REQ-013 overflow_out  output  1  set when an operand is dropped at the MAX_OPERANDS limit; held until transaction end.

Function
REQ-014 FSM states: IDLE, WAIT_OPCODE, OPERANDS.
REQ-015 IDLE -> WAIT_OPCODE when cs_active_in = 1; bytes arriving in IDLE are ignored.
REQ-016 In WAIT_OPCODE, an accepted byte is registered into op_code_out, op_code_valid_out = 1 on the next cycle, operand_count_out = 0, and the FSM moves to OPERANDS.
REQ-017 In OPERANDS, each accepted byte gives operand_out = byte, operand_count_out = previous + 1, and operand_valid_out = 1 for exactly one cycle, all on the cycle after byte_valid_in (latency 1).
REQ-018 A byte is accepted only when byte_valid_in = 1 and cs_active_in = 1 in the same cycle; a byte coinciding with cs_active_in = 0 is dropped.
REQ-019 operand_valid_out never asserts unless op_code_valid_out is 1 in the same cycle.
REQ-020 Once operand_count_out = MAX_OPERANDS, further bytes are dropped: no operand_valid_out, count unchanged, overflow_out = 1 next cycle.
REQ-021 cs_active_in = 0 in WAIT_OPCODE or OPERANDS sends the FSM to IDLE next cycle; op_code_valid_out, operand_valid_out, overflow_out, and operand_count_out go to 0 on that cycle.
REQ-022 transaction_done_out pulses one cycle coincident with that return to IDLE, only if an opcode was captured.
REQ-023 op_code_out and operand_out keep their last values after transaction end.
REQ-024 A cs drop and re-assertion within one cycle gap starts a fresh transaction: the next byte is an opcode.

Reset
REQ-025 While reset_n_in = 0, the FSM is in IDLE and every output is 0, independent of clock_in.
REQ-026 Reset asserted mid-transaction abandons it without a transaction_done_out pulse; after release the block waits for a new cs_active_in assertion.

Structure
REQ-027 The FSM state enum and the MAX_OPERANDS default live in a shared package, spi_pkg, alongside the opcode constants (0x10 assign color, 0x17 buffer show, 0x19 draw pixel).
REQ-028 Single flat module; no sub-module required.

Verification
REQ-029 cs = 1, bytes 0x10, 0xA5, 0x3C, 0x80, 0xE0, then cs = 0 -> op_code_out = 0x10 with valid high; operand strobes with counts 1..4 and data A5, 3C, 80, E0; one transaction_done_out pulse.
REQ-030 cs = 1, byte 0x17, cs = 0 -> op_code_valid_out high for the transaction, no operand_valid_out, one transaction_done_out pulse.
REQ-031 MAX_OPERANDS = 2, opcode 0x19 + 3 operands -> counts 1, 2 strobed; third byte dropped; overflow_out = 1 until cs = 0.
REQ-032 byte_valid_in in the same cycle as cs falling -> byte dropped; count unchanged; done pulse fires.
REQ-033 Bytes while cs = 0, and cs pulsed with no bytes -> no outputs change; no transaction_done_out pulse.
REQ-034 reset_n_in low after operand 2 of opcode 0x10 -> all outputs 0 immediately; a subsequent transaction 0x19, 0x07 -> operand count 1, data 0x07.
